// File: rtl/response_framer_pkg.sv
// response_framer_pkg: shared FSM encoding, frame-length helper and counter widths
package response_framer_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE} state_t;
  localparam int TIMEOUT_W = 8;
  localparam int BYTE_CNT_W = 3;
  function automatic int frame_len(input int data_bytes, input int checksum_en);
    return 1 + data_bytes + checksum_en;
  endfunction
endpackage

// File: rtl/response_queue.sv
// response_queue: synchronous FIFO of pending frames
// Ports: clock, reset_n (async active-low), push/din in, pop in, dout = head entry,
//        full/empty flags, count = occupancy (log2(DEPTH)+1 bits).
module response_queue #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/response_framer.sv
// response_framer: queues {code,data} requests and streams them as byte frames to a UART
// Ports: clock, reset_n (async active-low); has_response/response_code/data_to_send enqueue a frame;
//        tx_busy = UART busy level; response_ready strobes response (held between strobes);
//        queue_full, overflow (dropped request pulse), frame_done (frame complete pulse).
module response_framer
  import response_framer_pkg::*;
#(
  parameter int DATA_BYTES   = 2,
  parameter int CHECKSUM_EN  = 1,
  parameter int QUEUE_DEPTH  = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    has_response,
  input  logic [7:0]              response_code,
  input  logic [8*DATA_BYTES-1:0] data_to_send,
  input  logic                    tx_busy,
  output logic                    response_ready,
  output logic [7:0]              response,
  output logic                    queue_full,
  output logic                    overflow,
  output logic                    frame_done
);
  localparam int EW = 8 * (DATA_BYTES + 1);
  localparam int FLEN = frame_len(DATA_BYTES, CHECKSUM_EN);
  localparam int FW = 8 * FLEN;
  localparam int QCW = $clog2(QUEUE_DEPTH) + 1;
  state_t state, state_n;
  logic [EW-1:0] q_dout;
  logic [QCW-1:0] q_count;
  logic q_full, q_empty, q_pop;
  logic [FW-1:0] frame_w, sr, sr_n;
  logic [BYTE_CNT_W-1:0] cnt, cnt_n;
  logic [TIMEOUT_W-1:0] to_cnt, to_n;
  logic [7:0] byte_q, byte_n;
  response_queue #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clock(clock),
    .reset_n(reset_n),
    .push(has_response),
    .pop(q_pop),
    .din({response_code, data_to_send}),
    .dout(q_dout),
    .full(q_full),
    .empty(q_empty),
    .count(q_count)
  );
  assign queue_full = q_count == QCW'(QUEUE_DEPTH);
  generate
    if (CHECKSUM_EN != 0) begin : g_ck
      logic [7:0] chk;
      always_comb begin
        chk = 8'h00;
        for (int i = 0; i < EW / 8; i++) chk = chk ^ q_dout[8*i +: 8];
      end
      assign frame_w = {q_dout, chk};
    end else begin : g_nck
      assign frame_w = q_dout;
    end
  endgenerate
  // the byte being strobed is shown directly; afterwards the registered copy holds it
  assign response = response_ready ? sr[FW-1 -: 8] : byte_q;
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    to_n = '0;
    byte_n = byte_q;
    q_pop = 1'b0;
    response_ready = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          q_pop = 1'b1;
          sr_n = frame_w;
          cnt_n = BYTE_CNT_W'(FLEN);
          state_n = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          response_ready = 1'b1;
          byte_n = sr[FW-1 -: 8];
          state_n = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // a UART that never raises busy must not stall the frame forever
        if (tx_busy || to_cnt == TIMEOUT_W'(BUSY_TIMEOUT - 1)) state_n = WAIT_IDLE;
        else to_n = to_cnt + TIMEOUT_W'(1);
      end
      WAIT_IDLE: begin
        if (!tx_busy) begin
          frame_done = cnt == BYTE_CNT_W'(1);
          cnt_n = frame_done ? '0 : cnt - BYTE_CNT_W'(1);
          sr_n = frame_done ? sr : {sr[FW-9:0], 8'h00};
          state_n = frame_done ? IDLE : SEND;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      to_cnt <= '0;
      byte_q <= 8'h00;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      to_cnt <= to_n;
      byte_q <= byte_n;
      overflow <= has_response && q_full;
    end
  end
endmodule

// File: tb/tb_response_framer.sv
// tb_response_framer: scoreboard bench for response_framer (default build plus a 1-byte, no-checksum build)
module tb_response_framer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  logic has0 = 1'b0, busy0 = 1'b0;
  logic [7:0] code0 = '0;
  logic [15:0] data0 = '0;
  logic ready0, full0, ovf0, done0;
  logic [7:0] resp0;
  logic has1 = 1'b0, busy1 = 1'b0;
  logic [7:0] code1 = '0, data1 = '0;
  logic ready1, full1, ovf1, done1;
  logic [7:0] resp1;
  response_framer u0 (
    .clock(clock), .reset_n(reset_n), .has_response(has0), .response_code(code0),
    .data_to_send(data0), .tx_busy(busy0), .response_ready(ready0), .response(resp0),
    .queue_full(full0), .overflow(ovf0), .frame_done(done0)
  );
  response_framer #(.DATA_BYTES(1), .CHECKSUM_EN(0)) u1 (
    .clock(clock), .reset_n(reset_n), .has_response(has1), .response_code(code1),
    .data_to_send(data1), .tx_busy(busy1), .response_ready(ready1), .response(resp1),
    .queue_full(full1), .overflow(ovf1), .frame_done(done1)
  );
  int tests = 0, fails = 0, cyc = 0;
  int strobes0 = 0, strobes1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  int last_cyc0 = -1, last_cyc1 = -1, min_gap0 = 1000, max_gap0 = 0;
  int mode0 = 0, bcnt = 0;
  bit strobe_seen = 0;
  logic [7:0] exp0[$], exp1[$];
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // UART model: mode 0 = busy for 3 cycles after each strobe, 1 = stuck busy, 2 = dead (never busy)
  always @(posedge clock) begin
    #1;
    if (mode0 == 1) busy0 = 1'b1;
    else if (mode0 == 2) busy0 = 1'b0;
    else begin
      if (strobe_seen) bcnt = 3;
      else if (bcnt > 0) bcnt--;
      busy0 = bcnt > 0;
    end
    strobe_seen = 0;
  end
  always @(negedge clock) begin
    if (ready0 === 1'b1) begin
      strobes0++;
      strobe_seen = 1;
      if (last_cyc0 >= 0) begin
        if (cyc - last_cyc0 < min_gap0) min_gap0 = cyc - last_cyc0;
        if (cyc - last_cyc0 > max_gap0) max_gap0 = cyc - last_cyc0;
      end
      last_cyc0 = cyc;
      if (exp0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u0 unexpected strobe: got %0h expected none", resp0);
      end else check("u0 byte", 32'(resp0), 32'(exp0.pop_front()));
    end
    if (done0 === 1'b1) begin
      done_cnt0++;
      check("u0 done/ready exclusive", 32'(ready0), 0);
    end
    if (ready1 === 1'b1) begin
      strobes1++;
      last_cyc1 = cyc;
      if (exp1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL u1 unexpected strobe: got %0h expected none", resp1);
      end else check("u1 byte", 32'(resp1), 32'(exp1.pop_front()));
    end
    if (done1 === 1'b1) begin
      done_cnt1++;
      check("u1 done/ready exclusive", 32'(ready1), 0);
    end
  end
  function automatic void exp_frame0(input logic [7:0] c, input logic [15:0] d);
    exp0.push_back(c);
    exp0.push_back(d[15:8]);
    exp0.push_back(d[7:0]);
    exp0.push_back(c ^ d[15:8] ^ d[7:0]);
  endfunction
  task automatic send0(input logic [7:0] c, input logic [15:0] d);
    @(posedge clock);
    #1;
    code0 = c;
    data0 = d;
    has0 = 1'b1;
    exp_frame0(c, d);
    @(posedge clock);
    #1;
    has0 = 1'b0;
  endtask
  task automatic wait_done0(input int target, input int budget);
    int n = 0;
    while (done_cnt0 < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("u0 frame_done count", done_cnt0, target);
  endtask
  initial begin
    int c, base, s, d;
    repeat (3) @(posedge clock);
    #1;
    check("reset ready0", 32'(ready0), 0);
    check("reset resp0", 32'(resp0), 0);
    check("reset full0", 32'(full0), 0);
    check("reset ovf0", 32'(ovf0), 0);
    check("reset done0", 32'(done0), 0);
    check("reset ready1", 32'(ready1), 0);
    check("reset resp1", 32'(resp1), 0);
    check("reset ovf1", 32'(ovf1), 0);
    reset_n = 1'b1;
    @(posedge clock);
    send0(8'h01, 16'h1A2B);
    wait_done0(1, 200);
    check("u0 basic frame drained", exp0.size(), 0);
    @(posedge clock);
    #1;
    c = cyc;
    code1 = 8'h02;
    data1 = 8'h55;
    has1 = 1'b1;
    exp1.push_back(8'h02);
    exp1.push_back(8'h55);
    base = strobes1;
    @(posedge clock);
    #1;
    has1 = 1'b0;
    for (int n = 0; n < 50 && strobes1 == base; n++) @(posedge clock);
    check("u1 first-strobe latency", last_cyc1 - c, 2);
    for (int n = 0; n < 200 && done_cnt1 < 1; n++) @(posedge clock);
    check("u1 frame_done count", done_cnt1, 1);
    check("u1 frame drained", exp1.size(), 0);
    send0(8'hFF, 16'h00FF);
    wait_done0(2, 200);
    mode0 = 1;
    repeat (2) @(posedge clock);
    send0(8'hA0, 16'h1234);
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) begin
      code0 = 8'hB0 + 8'(i);
      data0 = {8'(i), 8'hC0 + 8'(i)};
      has0 = 1'b1;
      if (i < 4) exp_frame0(code0, data0);
      @(posedge clock);
      @(negedge clock);
      if (i == 2) check("not full after 3rd", 32'(full0), 0);
      if (i == 3) begin
        check("full after 4th", 32'(full0), 1);
        check("no overflow before 5th", 32'(ovf0), 0);
      end
      if (i == 4) begin
        check("overflow for 5th", 32'(ovf0), 1);
        check("still full after drop", 32'(full0), 1);
      end
    end
    has0 = 1'b0;
    @(negedge clock);
    check("overflow is one cycle", 32'(ovf0), 0);
    mode0 = 0;
    wait_done0(7, 600);
    check("fifo order frames drained", exp0.size(), 0);
    mode0 = 2;
    repeat (2) @(posedge clock);
    last_cyc0 = -1;
    min_gap0 = 1000;
    max_gap0 = 0;
    send0(8'h3C, 16'hA55A);
    wait_done0(8, 300);
    check("dead uart drained", exp0.size(), 0);
    check("dead uart min gap >= timeout", 32'(min_gap0 >= 8), 1);
    check("dead uart max gap <= timeout+2", 32'(max_gap0 <= 10), 1);
    mode0 = 0;
    repeat (2) @(posedge clock);
    base = strobes0;
    send0(8'hF1, 16'h0102);
    send0(8'hF2, 16'h0304);
    send0(8'hF3, 16'h0506);
    for (int n = 0; n < 100 && strobes0 < base + 2; n++) @(posedge clock);
    check("two bytes before reset", strobes0 - base, 2);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid reset ready0", 32'(ready0), 0);
    check("mid reset resp0", 32'(resp0), 0);
    check("mid reset done0", 32'(done0), 0);
    check("mid reset ovf0", 32'(ovf0), 0);
    check("mid reset full0", 32'(full0), 0);
    exp0.delete();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    s = strobes0;
    d = done_cnt0;
    repeat (60) @(posedge clock);
    check("no strobes after reset", strobes0, s);
    check("no frame_done after reset", done_cnt0, d);
    send0(8'h77, 16'h0000);
    wait_done0(d + 1, 200);
    check("post-reset frame drained", exp0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/response_framer.md
RESPONSE_FRAMER -- requirements
Module: response_framer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2, number of data bytes per frame (range 1..4).
REQ-002 SHALL have parameter CHECKSUM_EN, default 1, which appends an XOR checksum byte when 1.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, pending-frame queue entries (power of 2, >= 2).
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 8, cycles to wait for tx_busy to rise after a byte strobe.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  rising-edge system clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 has_response  input  1  one-cycle request to enqueue a frame.
REQ-009 response_code  input  8  frame code byte, sampled with has_response.
REQ-010 data_to_send  input  8*DATA_BYTES  frame payload, MSB byte sent first, sampled with has_response.
REQ-011 tx_busy  input  1  UART transmitter busy level.
REQ-012 response_ready  output  1  one-cycle strobe: response holds a byte for the UART.
REQ-013 response  output  8  byte to transmit; holds its value until the next strobe.
REQ-014 queue_full  output  1  queue holds QUEUE_DEPTH entries.
REQ-015 overflow  output  1  one-cycle pulse: has_response was dropped.
REQ-016 frame_done  output  1  one-cycle pulse after the last byte of a frame completes.

Function
REQ-017 Frame SHALL be: code, data bytes MSB-first, then checksum if CHECKSUM_EN; length = 1 + DATA_BYTES + CHECKSUM_EN.
REQ-018 Checksum SHALL be the bitwise XOR of the code byte and all data bytes of that frame.
REQ-019 has_response SHALL push {code, data} iff the entry count < QUEUE_DEPTH at that edge, independent of a same-cycle pop.
REQ-020 has_response while full SHALL drop the request and pulse overflow the next cycle; the queue SHALL be unchanged.
REQ-021 The FSM SHALL have states IDLE, SEND, WAIT_BUSY and WAIT_IDLE.
REQ-022 IDLE: when the queue is non-empty, the FSM SHALL pop the head entry, load the frame shift register, set the byte counter to the frame length, and go to SEND.
REQ-023 SEND: when tx_busy=0, the FSM SHALL drive the current byte on response, pulse response_ready for exactly one cycle, and go to WAIT_BUSY; otherwise it SHALL hold.
REQ-024 WAIT_BUSY: when tx_busy=1, or BUSY_TIMEOUT cycles elapse without it, the FSM SHALL go to WAIT_IDLE.
REQ-025 WAIT_IDLE: when tx_busy=0 and the byte is the last, the FSM SHALL pulse frame_done and go to IDLE.
REQ-026 WAIT_IDLE: when tx_busy=0 and bytes remain, the FSM SHALL advance to the next byte and go to SEND.
REQ-027 Latency from an accepted has_response (queue empty, IDLE, tx_busy=0) to the first response_ready SHALL be exactly 2 cycles.
REQ-028 Frames SHALL be sent in FIFO order with no interleaving; a new frame SHALL start only from IDLE.
REQ-029 Queue pointers SHALL wrap modulo QUEUE_DEPTH; the count SHALL be log2(QUEUE_DEPTH)+1 bits wide.
REQ-030 response_ready and frame_done SHALL never be high in the same cycle.

Reset
REQ-031 On reset_n=0, state SHALL be IDLE, the queue SHALL be empty, and the byte counter and timeout counter SHALL be 0.
REQ-032 On reset_n=0, response_ready, overflow and frame_done SHALL be 0 and response SHALL be 8'h00.
REQ-033 Reset mid-frame SHALL discard the in-flight frame and all queued frames; no further strobes SHALL follow for them.

Structure
REQ-034 Package response_framer_pkg SHALL hold the FSM state encoding, the frame-length function and the timeout counter width constant.
REQ-035 The queue SHALL be a sub-module named response_queue (synchronous FIFO: push, pop, full, empty, count).

Verification
REQ-036 With defaults, code 0x01 and data 0x1A2B, UART model busy 3 cycles per byte -> bytes 0x01, 0x1A, 0x2B, 0x30 with one strobe each, then frame_done once.
REQ-037 With CHECKSUM_EN=0, DATA_BYTES=1, code 0x02 and data 0x55 -> bytes 0x02, 0x55 only; first strobe exactly 2 cycles after has_response.
REQ-038 Five back-to-back has_response pulses with tx_busy stuck at 1 -> queue_full after the 4th, overflow pulse for the 5th, and the four queued frames emitted in order once tx_busy=0.
REQ-039 tx_busy held at 0 (dead UART) -> each byte advances after BUSY_TIMEOUT=8 cycles; the frame still completes with frame_done.
REQ-040 reset_n asserted after the 2nd byte of a frame with 2 frames queued -> outputs 0 immediately; no strobe after reset release until a new has_response.
